mips_multicycle_control: RTL

Multicycle control unit for the lab MIPS datapath: decodes the latched instruction and sequences it through FETCH/DECODE/execute/writeback states. It drives the ALU opcode and operand selects, and consumes the ALU `equal` flag for branches. It is the producer end of the ALU opcode interface and owns every datapath enable and mux select. Memory accesses stall on a ready handshake.

---
 rtl/mips_multicycle_control_pkg.sv | 71 +++++++
 rtl/mips_multicycle_control_alu_op_decoder.sv | 68 ++++++
 rtl/mips_multicycle_control.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, functs,
// ALU opcode encodings, mux select codes and the FSM state encoding.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_OR  = 4'd3;
    localparam logic [3:0] ALU_OP_XOR = 4'd4;
    localparam logic [3:0] ALU_OP_NOR = 4'd5;
    localparam logic [3:0] ALU_OP_SLT = 4'd6;
    localparam logic [3:0] ALU_OP_SLL = 4'd7;
    localparam logic [3:0] ALU_OP_SRL = 4'd8;
    localparam logic [3:0] ALU_OP_SRA = 4'd9;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_REG   = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;

    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB_R  = 4'd9,
        S_ALU_WB_I  = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

endpackage

// File: rtl/mips_multicycle_control_alu_op_decoder.sv
// Combinational ALU opcode / x-operand / immediate-extension decode for the
// current control state; also flags whether an R-type funct is recognised.
module alu_op_decoder
    import mips_multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op_code,
    output logic [1:0] alu_src_a,
    output logic       imm_zero_ext,
    output logic       funct_valid
);

    logic [3:0] r_op;
    logic       r_shift;

    always_comb begin
        funct_valid = 1'b1;
        r_op        = ALU_OP_ADD;
        r_shift     = 1'b0;
        case (funct)
            FN_SLL:          begin r_op = ALU_OP_SLL; r_shift = 1'b1; end
            FN_SRL:          begin r_op = ALU_OP_SRL; r_shift = 1'b1; end
            FN_SRA:          begin r_op = ALU_OP_SRA; r_shift = 1'b1; end
            FN_ADD, FN_ADDU: r_op = ALU_OP_ADD;
            FN_SUB, FN_SUBU: r_op = ALU_OP_SUB;
            FN_AND:          r_op = ALU_OP_AND;
            FN_OR:           r_op = ALU_OP_OR;
            FN_XOR:          r_op = ALU_OP_XOR;
            FN_NOR:          r_op = ALU_OP_NOR;
            FN_SLT:          r_op = ALU_OP_SLT;
            default:         funct_valid = 1'b0;
        endcase
    end

    // Idle states fall through to PC + ADD with sign extension.
    always_comb begin
        alu_op_code  = ALU_OP_ADD;
        alu_src_a    = SRC_A_PC;
        imm_zero_ext = 1'b0;
        case (state)
            S_MEM_ADR: alu_src_a = SRC_A_REG;
            S_EXEC_R: begin
                if (funct_valid) begin
                    alu_op_code = r_op;
                    alu_src_a   = r_shift ? SRC_A_SHAMT : SRC_A_REG;
                end
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_REG;
                case (opcode)
                    OP_SLTI: alu_op_code = ALU_OP_SLT;
                    OP_ANDI: begin alu_op_code = ALU_OP_AND; imm_zero_ext = 1'b1; end
                    OP_ORI:  begin alu_op_code = ALU_OP_OR;  imm_zero_ext = 1'b1; end
                    OP_XORI: begin alu_op_code = ALU_OP_XOR; imm_zero_ext = 1'b1; end
                    default: alu_op_code = ALU_OP_ADD;
                endcase
            end
            S_BRANCH: begin
                alu_op_code = ALU_OP_SUB;
                alu_src_a   = SRC_A_REG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and
// drives every datapath enable and select; memory states stall on mem_ready.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       equal,
    input  logic       mem_ready,
    output logic [3:0] alu_op_code,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zero_ext,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       illegal_instr,
    output logic [3:0] state
);

    localparam int HOLD = (RESET_PC_HOLD < 1) ? 1 : RESET_PC_HOLD;
    localparam int CW   = $clog2(HOLD + 1);

    state_t          st;
    logic [CW-1:0]   hold_cnt;
    logic            funct_valid;

    assign state = st;

    alu_op_decoder u_alu_dec (
        .state        (st),
        .opcode       (opcode),
        .funct        (funct),
        .alu_op_code  (alu_op_code),
        .alu_src_a    (alu_src_a),
        .imm_zero_ext (imm_zero_ext),
        .funct_valid  (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            st            <= S_RESET;
            hold_cnt      <= '0;
            illegal_instr <= 1'b0;
        end else begin
            case (st)
                S_RESET: begin
                    if (hold_cnt == CW'(HOLD - 1)) st <= S_FETCH;
                    else                           hold_cnt <= hold_cnt + CW'(1);
                end
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:                                st <= S_MEM_ADR;
                        OP_RTYPE:                                    st <= S_EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:  st <= S_EXEC_I;
                        OP_BEQ, OP_BNE:                              st <= S_BRANCH;
                        OP_J:                                        st <= S_JUMP;
                        default: begin
                            st            <= S_ILLEGAL;
                            illegal_instr <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADR:   st <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (mem_ready) st <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) st <= S_FETCH;
                S_EXEC_R: begin
                    if (funct_valid) st <= S_ALU_WB_R;
                    else begin
                        st            <= S_ILLEGAL;
                        illegal_instr <= 1'b1;
                    end
                end
                S_EXEC_I: st <= S_ALU_WB_I;
                S_MEM_WB, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: st <= S_FETCH;
                S_ILLEGAL: illegal_instr <= 1'b1;
                default:   st <= S_RESET;
            endcase
        end
    end

    // Moore decode; only FETCH/memory handshakes and the branch condition
    // look at live inputs.
    always_comb begin
        alu_src_b  = SRC_B_REG;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        case (st)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = SRC_B_IMM_SH2;
            S_MEM_ADR:   alu_src_b = SRC_B_IMM;
            S_MEM_READ:  begin mem_rd = 1'b1; i_or_d = 1'b1; end
            S_MEM_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEM_WRITE: begin mem_wr = 1'b1; i_or_d = 1'b1; end
            S_EXEC_R:    reg_dst = 1'b1;
            S_EXEC_I:    alu_src_b = SRC_B_IMM;
            S_ALU_WB_R:  begin reg_write = 1'b1; reg_dst = 1'b1; end
            S_ALU_WB_I:  reg_write = 1'b1;
            S_BRANCH: begin
                pc_src   = PC_SRC_ALUOUT;
                pc_write = (opcode == OP_BNE) ? !equal : equal;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
